// File: rtl/ram_pkg.sv
// Shared state encoding and default widths for the RAM burst reader.
package ram_pkg;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN
    } ram_state_t;

    localparam int DEF_RAM_WIDTH = 8;
    localparam int DEF_ADDR_SIZE = 4;

endpackage

// File: rtl/ram_rd_skid_fifo.sv
// Two-entry buffer absorbing RAM read latency between issue and downstream accept.
module ram_rd_skid_fifo #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             valid,
    output logic [WIDTH-1:0] data,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] mem [2];
    logic             wr_ptr;
    logic             rd_ptr;

    always_ff @(posedge clk) begin
        if (reset) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    assign valid = (count != 2'd0);
    assign data  = mem[rd_ptr];

endmodule

// File: rtl/ram_burst_reader.sv
// Streams a burst of RAM words (registered read port) out through a valid/ready interface.
// Optional RAM_BURST_READER_LAST_EN adds out_last flagging the final word of each burst.
module ram_burst_reader
    import ram_pkg::*;
#(
    parameter int RAM_WIDTH = DEF_RAM_WIDTH,
    parameter int ADDR_SIZE = DEF_ADDR_SIZE
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [ADDR_SIZE-1:0] base_addr,
    input  logic [ADDR_SIZE:0]   burst_len,
    output logic                 ram_rd_en,
    output logic [ADDR_SIZE-1:0] ram_rd_addr,
    input  logic [RAM_WIDTH-1:0] ram_rd_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [RAM_WIDTH-1:0] out_data,
`ifdef RAM_BURST_READER_LAST_EN
    output logic                 out_last,
`endif
    output logic                 busy,
    output logic                 done
);

    ram_state_t           state;
    ram_state_t           state_next;
    logic                 done_next;
    logic [ADDR_SIZE:0]   issue_rem;
    logic [ADDR_SIZE:0]   out_rem;
    logic [ADDR_SIZE-1:0] rd_addr;
    logic                 rd_pending;
    logic                 rd_en;
    logic                 pop;
    logic [1:0]           fifo_count;
    logic [2:0]           occ_next;

`ifdef RAM_BURST_READER_LAST_EN
    localparam int FW = RAM_WIDTH + 1;
    logic rd_last_pending;
`else
    localparam int FW = RAM_WIDTH;
`endif
    logic [FW-1:0] push_data;
    logic [FW-1:0] fifo_data;

    assign pop = out_valid & out_ready;

    // Buffer slots already spoken for at the next edge; a new read needs one free.
    assign occ_next = {1'b0, fifo_count} + {2'b00, rd_pending} - {2'b00, pop};
    assign rd_en    = ~reset && (state == READ) && (issue_rem != '0) && (occ_next < 3'd2);

    always_comb begin
        state_next = state;
        done_next  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (burst_len != '0) state_next = READ;
                    else                 done_next  = 1'b1;
                end
            end
            READ: begin
                if (rd_en && issue_rem == (ADDR_SIZE+1)'(1)) state_next = DRAIN;
            end
            DRAIN: begin
                if (pop && out_rem == (ADDR_SIZE+1)'(1)) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            done       <= 1'b0;
            issue_rem  <= '0;
            out_rem    <= '0;
            rd_addr    <= '0;
            rd_pending <= 1'b0;
        end else begin
            state      <= state_next;
            done       <= done_next;
            rd_pending <= rd_en;
            if (state == IDLE && start && burst_len != '0) begin
                rd_addr   <= base_addr;
                issue_rem <= burst_len;
                out_rem   <= burst_len;
            end else begin
                if (rd_en) begin
                    rd_addr   <= rd_addr + ADDR_SIZE'(1);
                    issue_rem <= issue_rem - (ADDR_SIZE+1)'(1);
                end
                if (pop) begin
                    out_rem <= out_rem - (ADDR_SIZE+1)'(1);
                end
            end
        end
    end

`ifdef RAM_BURST_READER_LAST_EN
    always_ff @(posedge clk) begin
        if (reset) rd_last_pending <= 1'b0;
        else       rd_last_pending <= rd_en && (issue_rem == (ADDR_SIZE+1)'(1));
    end

    assign push_data = {rd_last_pending, ram_rd_data};
    assign out_data  = fifo_data[RAM_WIDTH-1:0];
    assign out_last  = out_valid & fifo_data[RAM_WIDTH];
`else
    assign push_data = ram_rd_data;
    assign out_data  = fifo_data;
`endif

    ram_rd_skid_fifo #(
        .WIDTH(FW)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (rd_pending),
        .push_data(push_data),
        .pop      (pop),
        .valid    (out_valid),
        .data     (fifo_data),
        .count    (fifo_count)
    );

    assign ram_rd_en   = rd_en;
    assign ram_rd_addr = rd_addr;
    assign busy        = (state != IDLE);

endmodule

// File: tb/tb_ram_burst_reader.sv
// Randomized and directed bench for ram_burst_reader against a queue-based word-order model.
module tb_ram_burst_reader;

    localparam int RW = 8;
    localparam int AS = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [AS-1:0] base_addr;
    logic [AS:0]   burst_len;
    logic          ram_rd_en;
    logic [AS-1:0] ram_rd_addr;
    logic [RW-1:0] ram_rd_data = '0;
    logic          out_valid;
    logic          out_ready;
    logic [RW-1:0] out_data;
    logic          busy;
    logic          done;
`ifdef RAM_BURST_READER_LAST_EN
    logic          out_last;
`endif

    int total = 0;
    int bad = 0;
    int done_cnt = 0;
    int issued = 0;
    int popped = 0;
    int cur_base = 0;
    int burst_issued = 0;
    int ready_mode = 0;
    int phase = 0;
    logic [RW-1:0] exp_q[$];
    logic          exp_last_q[$];
    logic          prev_stall = 1'b0;
    logic [RW-1:0] prev_data = '0;

    ram_burst_reader #(
        .RAM_WIDTH(RW),
        .ADDR_SIZE(AS)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .base_addr  (base_addr),
        .burst_len  (burst_len),
        .ram_rd_en  (ram_rd_en),
        .ram_rd_addr(ram_rd_addr),
        .ram_rd_data(ram_rd_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
`ifdef RAM_BURST_READER_LAST_EN
        .out_last   (out_last),
`endif
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    // RAM preloaded with mem[i] = i + 0x10, one-cycle registered read.
    always @(posedge clk) begin
        if (ram_rd_en) ram_rd_data <= 8'(ram_rd_addr) + 8'h10;
    end

    function automatic logic [RW-1:0] mem_word(input int a);
        return 8'((a % 16) + 16);
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, want);
        end
    endtask

    // Scoreboard: address sequence, word order, stall stability, outstanding-read bound.
    always @(negedge clk) begin
        if (reset) begin
            prev_stall = 1'b0;
            issued     = 0;
            popped     = 0;
        end else begin
            if (done) done_cnt++;
            if (ram_rd_en) begin
                chk("rd_addr", 32'(ram_rd_addr), 32'((cur_base + burst_issued) % 16));
                burst_issued++;
                issued++;
            end
            if (prev_stall) begin
                chk("hold_valid", 32'(out_valid), 32'd1);
                chk("hold_data", 32'(out_data), 32'(prev_data));
            end
            if (out_valid && out_ready) begin
                popped++;
                if (exp_q.size() == 0) chk("extra_word", 32'(exp_q.size()), 32'd1);
                else                   chk("data", 32'(out_data), 32'(exp_q.pop_front()));
`ifdef RAM_BURST_READER_LAST_EN
                if (exp_last_q.size() != 0) chk("last", 32'(out_last), 32'(exp_last_q.pop_front()));
`endif
            end
            if (ram_rd_en || (out_valid && out_ready))
                chk("pending", 32'((issued - popped) <= 2), 32'd1);
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
        end
    end

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'($urandom_range(0, 1));
                default: out_ready = (phase % 3 == 0);
            endcase
            phase++;
        end
    end

    task automatic launch(input int b, input int l);
        for (int i = 0; i < l; i++) begin
            exp_q.push_back(mem_word(b + i));
            exp_last_q.push_back(i == l - 1);
        end
        @(posedge clk);
        #1;
        start        = 1'b1;
        base_addr    = 4'(b);
        burst_len    = 5'(l);
        cur_base     = b;
        burst_issued = 0;
    endtask

    task automatic drop_start();
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int d0);
        for (int n = 0; n < 400 && done_cnt == d0; n++) @(negedge clk);
        chk("done_pulse", 32'(done_cnt - d0), 32'd1);
        chk("all_words", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic run_burst(input int b, input int l);
        int d0;
        d0 = done_cnt;
        launch(b, l);
        drop_start();
        wait_done(d0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        exp_q.delete();
        exp_last_q.delete();
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_rd_en", 32'(ram_rd_en), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_addr", 32'(ram_rd_addr), 32'd0);
        chk("rst_data", 32'(out_data), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        int i0;
        reset     = 1'b1;
        start     = 1'b0;
        base_addr = '0;
        burst_len = '0;
        do_reset();

        // Cycle-exact latency: words on cycles 3..6, done on cycle 7.
        ready_mode = 0;
        d0 = done_cnt;
        launch(2, 4);
        for (int k = 0; k <= 8; k++) begin
            if (k != 0) @(negedge clk);
            else        @(negedge clk);
            chk("lat_valid", 32'(out_valid), 32'(k >= 3 && k <= 6));
            if (k >= 3 && k <= 6) chk("lat_data", 32'(out_data), 32'(8'h12 + 8'(k - 3)));
            chk("lat_done", 32'(done), 32'(k == 7));
            chk("lat_busy", 32'(busy), 32'(k >= 1 && k <= 6));
            if (k == 0) drop_start();
        end
        chk("lat_done_cnt", 32'(done_cnt - d0), 32'd1);

        run_burst(14, 4);

        ready_mode = 2;
        run_burst(6, 5);

        // Zero-length request: no reads, done on the following cycle.
        ready_mode = 0;
        @(posedge clk);
        #1;
        start     = 1'b1;
        base_addr = 4'd5;
        burst_len = '0;
        @(negedge clk);
        chk("len0_rd_en", 32'(ram_rd_en), 32'd0);
        chk("len0_busy", 32'(busy), 32'd0);
        drop_start();
        @(negedge clk);
        chk("len0_done", 32'(done), 32'd1);
        chk("len0_rd_en2", 32'(ram_rd_en), 32'd0);
        @(negedge clk);
        chk("len0_done_off", 32'(done), 32'd0);

        // A second start while busy must not disturb the running burst.
        ready_mode = 1;
        i0 = issued;
        d0 = done_cnt;
        launch(3, 6);
        drop_start();
        repeat (2) @(posedge clk);
        #1;
        start     = 1'b1;
        base_addr = 4'd10;
        burst_len = 5'd2;
        drop_start();
        wait_done(d0);
        repeat (4) @(negedge clk);
        chk("ignore_reads", 32'(issued - i0), 32'd6);
        chk("ignore_busy", 32'(busy), 32'd0);

        // Reset two cycles into a long burst.
        ready_mode = 0;
        launch(0, 8);
        drop_start();
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        exp_q.delete();
        exp_last_q.delete();
        @(negedge clk);
        chk("abort_valid", 32'(out_valid), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        run_burst(0, 1);
        repeat (4) @(negedge clk);
        chk("abort_words", 32'(popped), 32'd1);

        run_burst(7, 3);

        ready_mode = 1;
        for (int n = 0; n < 10; n++) run_burst(int'($urandom_range(0, 15)), int'($urandom_range(1, 16)));
        run_burst(9, 16);
        ready_mode = 0;
        run_burst(5, 16);

        repeat (5) @(negedge clk);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_valid", 32'(out_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ram_burst_reader.md
RAM_BURST_READER -- requirements
Module: ram_burst_reader

Interface
REQ-001 SHALL have parameter RAM_WIDTH, default 8, data word width.
REQ-002 SHALL have parameter ADDR_SIZE, default 4, RAM address width; depth = 2**ADDR_SIZE.
REQ-003 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  burst request, sampled only in IDLE.
REQ-006 SHALL have port base_addr  input  ADDR_SIZE  first RAM address of burst.
REQ-007 SHALL have port burst_len  input  ADDR_SIZE+1  word count, 0..2**ADDR_SIZE.
REQ-008 SHALL have port ram_rd_en  output  1  read enable to RAM read port.
REQ-009 SHALL have port ram_rd_addr  output  ADDR_SIZE  read address to RAM.
REQ-010 SHALL have port ram_rd_data  input  RAM_WIDTH  RAM registered read data, valid the cycle after ram_rd_en.
REQ-011 SHALL have port out_valid  output  1  stream word valid.
REQ-012 SHALL have port out_ready  input  1  downstream accept.
REQ-013 SHALL have port out_data  output  RAM_WIDTH  stream word.
REQ-014 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-015 SHALL have port done  output  1  one-cycle pulse on burst completion.

Function
REQ-016 SHALL implement FSM states IDLE, READ, DRAIN.
REQ-017 IDLE->READ SHALL occur when start=1 and burst_len!=0, latching base_addr and burst_len; start with burst_len=0 SHALL stay in IDLE and pulse done next cycle.
REQ-018 start outside IDLE SHALL be ignored.
REQ-019 In READ, ram_rd_en SHALL assert only when words remaining>0 and (buffer occupancy + in-flight read - pop this cycle) < 2.
REQ-020 ram_rd_addr SHALL equal latched base + issued count, modulo 2**ADDR_SIZE (wrap-around, no error).
REQ-021 Data SHALL be captured from ram_rd_data into a 2-entry FIFO exactly one cycle after each ram_rd_en; no word is lost or duplicated under any out_ready pattern.
REQ-022 Output SHALL be in address order; out_data stable while out_valid=1 and out_ready=0.
REQ-023 With out_ready held 1, first out_valid SHALL occur 3 cycles after the start cycle and throughput SHALL be 1 word/cycle.
REQ-024 READ->DRAIN after the last read issues; DRAIN->IDLE on the handshake of the last word, done pulsing in the following cycle (busy low in that same cycle).
REQ-025 Simultaneous capture and pop in one cycle SHALL leave occupancy unchanged.

Reset
REQ-026 On reset: state IDLE, FIFO empty, counters 0; out_valid, ram_rd_en, busy, done = 0; ram_rd_addr, out_data = 0.
REQ-027 Reset mid-burst SHALL abort the burst; in-flight RAM data in the next cycle SHALL be discarded.

Configuration
REQ-028 Macro RAM_BURST_READER_LAST_EN defined: SHALL add output out_last (1 bit), high with out_valid on the final word of each burst, reset 0.
REQ-029 Macro undefined: out_last port and its logic SHALL be absent; all other behaviour identical.

Structure
REQ-030 FSM state enum and default width constants SHALL live in shared package ram_pkg.
REQ-031 The 2-entry buffer SHALL be a sub-module ram_rd_skid_fifo; counters and FSM stay in the top.

Verification
REQ-032 RAM preloaded mem[i]=i+8'h10; start, base=2, len=4, out_ready=1 -> out_data 12,13,14,15 on cycles 3..6, done at cycle 7.
REQ-033 base=14, len=4 -> addresses 14,15,0,1; data 1E,1F,10,11.
REQ-034 len=5, out_ready toggles 1,0,0,1,... -> exactly 5 words in order, no drops/duplicates, ram_rd_en never leaves >2 words pending.
REQ-035 reset asserted 2 cycles into len=8 burst -> next cycle out_valid=0, busy=0; new burst base=0, len=1 returns 10 only.
REQ-036 start with len=0 -> no ram_rd_en, done pulse next cycle; start during busy -> ignored, burst unchanged.
REQ-037 With RAM_BURST_READER_LAST_EN, len=3 -> out_last high only with third word.
